// File: rtl/hdmi_cfg_pkg.sv
// Shared definitions for the MS72xx configuration sequencer: state encoding,
// ROM entry layout and the default transmitter IIC address.
package hdmi_cfg_pkg;

  typedef enum logic [2:0] {
    ST_WAIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_REQ   = 3'd2,
    ST_XFER  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5,
    ST_FAIL  = 3'd6
  } cfg_state_t;

  // One ROM entry is {register address[15:0], register data[7:0]}.
  localparam int ROM_W = 24;

  localparam logic [7:0] DEFAULT_DEV_ADDR = 8'hB2;

endpackage

// File: rtl/hdmi_cfg_rom.sv
// MS72xx register-write table. Synchronous read with one cycle of latency;
// indices past the end of the table read back as zero.
module hdmi_cfg_rom
  import hdmi_cfg_pkg::*;
(
  input  logic             clk,
  input  logic [7:0]       idx,
  output logic [ROM_W-1:0] data
);

  logic [ROM_W-1:0] rom_d;

  always_comb begin
    rom_d = '0;
    case (idx)
      8'd0:  rom_d = 24'h128104;  8'd1:  rom_d = 24'h001604;  8'd2:  rom_d = 24'h000901;  8'd3:  rom_d = 24'h000709;
      8'd4:  rom_d = 24'h000A7B;  8'd5:  rom_d = 24'h00170F;  8'd6:  rom_d = 24'h001605;  8'd7:  rom_d = 24'h001202;
      8'd8:  rom_d = 24'h120020;  8'd9:  rom_d = 24'h120101;  8'd10: rom_d = 24'h120263;  8'd11: rom_d = 24'h120300;
      8'd12: rom_d = 24'h120410;  8'd13: rom_d = 24'h120505;  8'd14: rom_d = 24'h120620;  8'd15: rom_d = 24'h120703;
      8'd16: rom_d = 24'h12082C;  8'd17: rom_d = 24'h120900;  8'd18: rom_d = 24'h120A05;  8'd19: rom_d = 24'h120B00;
      8'd20: rom_d = 24'h120C19;  8'd21: rom_d = 24'h120D00;  8'd22: rom_d = 24'h120E94;  8'd23: rom_d = 24'h120F04;
      8'd24: rom_d = 24'h121065;  8'd25: rom_d = 24'h121104;  8'd26: rom_d = 24'h121258;  8'd27: rom_d = 24'h121302;
      8'd28: rom_d = 24'h121480;  8'd29: rom_d = 24'h121507;  8'd30: rom_d = 24'h121638;  8'd31: rom_d = 24'h121704;
      8'd32: rom_d = 24'h130011;  8'd33: rom_d = 24'h130100;  8'd34: rom_d = 24'h130240;  8'd35: rom_d = 24'h130300;
      8'd36: rom_d = 24'h131001;  8'd37: rom_d = 24'h131100;  8'd38: rom_d = 24'h131200;  8'd39: rom_d = 24'h131300;
      8'd40: rom_d = 24'h140001;  8'd41: rom_d = 24'h140110;  8'd42: rom_d = 24'h140202;  8'd43: rom_d = 24'h140300;
      8'd44: rom_d = 24'h150080;  8'd45: rom_d = 24'h150100;  8'd46: rom_d = 24'h150218;  8'd47: rom_d = 24'h150300;
      8'd48: rom_d = 24'h160001;  8'd49: rom_d = 24'h160102;  8'd50: rom_d = 24'h160200;  8'd51: rom_d = 24'h160300;
      8'd52: rom_d = 24'h170010;  8'd53: rom_d = 24'h170120;  8'd54: rom_d = 24'h170230;  8'd55: rom_d = 24'h170340;
      8'd56: rom_d = 24'h180082;  8'd57: rom_d = 24'h180102;  8'd58: rom_d = 24'h18020D;  8'd59: rom_d = 24'h180300;
      8'd60: rom_d = 24'h002003;  8'd61: rom_d = 24'h001201;  8'd62: rom_d = 24'h001640;  8'd63: rom_d = 24'h128105;
      default: rom_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    data <= rom_d;
  end

endmodule

// File: rtl/hdmi_cfg_seq.sv
// Power-on register-write sequencer for the MS72xx HDMI transmitter: walks the
// configuration ROM, hands each write to the IIC master and retries NACKs.
module hdmi_cfg_seq
  import hdmi_cfg_pkg::*;
#(
  parameter logic [7:0]  CFG_NUM     = 8'd64,
  parameter logic [7:0]  DEV_ADDR    = DEFAULT_DEV_ADDR,
  parameter logic [15:0] STARTUP_CYC = 16'd10000,
  parameter logic [7:0]  GAP_CYC     = 8'd20,
  parameter logic [2:0]  MAX_RETRY   = 3'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reinit,
  output logic        iic_req,
  output logic [7:0]  iic_dev,
  output logic [15:0] iic_addr,
  output logic [7:0]  iic_wdata,
  input  logic        iic_ack,
  input  logic        iic_done,
  input  logic        iic_nack,
  output logic        init_over,
  output logic        cfg_err,
  output logic [7:0]  err_idx,
  output logic        busy,
  output cfg_state_t  dbg_state
);

  // Handshake: iic_req is a level request that stays high, with iic_addr and
  // iic_wdata frozen, until a cycle where iic_ack is high; that cycle is the
  // transfer. iic_done (qualified by iic_nack) closes it. Strays are ignored.

  cfg_state_t        state, state_n;
  logic [7:0]        idx, idx_n;
  logic [15:0]       cnt, cnt_n;
  logic [2:0]        retry, retry_n;
  logic              fetch_ph, fetch_ph_n;
  logic              req_n, init_over_n, cfg_err_n, busy_n;
  logic [15:0]       addr_n;
  logic [7:0]        wdata_n, err_idx_n;
  logic [ROM_W-1:0]  rom_q;

  hdmi_cfg_rom u_rom (
    .clk  (clk),
    .idx  (idx),
    .data (rom_q)
  );

  assign iic_dev   = DEV_ADDR;
  assign dbg_state = state;

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    cnt_n       = cnt;
    retry_n     = retry;
    fetch_ph_n  = 1'b0;
    req_n       = iic_req;
    addr_n      = iic_addr;
    wdata_n     = iic_wdata;
    init_over_n = init_over;
    cfg_err_n   = cfg_err;
    err_idx_n   = err_idx;
    case (state)
      ST_WAIT: begin
        if (cnt == STARTUP_CYC - 16'd1) begin
          state_n = ST_FETCH;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      // First FETCH cycle lets the ROM read idx; the second latches its output.
      ST_FETCH: begin
        if (!fetch_ph) begin
          fetch_ph_n = 1'b1;
        end else begin
          addr_n  = rom_q[23:8];
          wdata_n = rom_q[7:0];
          req_n   = 1'b1;
          state_n = ST_REQ;
        end
      end
      ST_REQ: begin
        if (iic_ack) begin
          req_n   = 1'b0;
          state_n = ST_XFER;
        end
      end
      ST_XFER: begin
        if (iic_done) begin
          if (!iic_nack) begin
            retry_n = '0;
            if (idx == CFG_NUM - 8'd1) begin
              state_n     = ST_DONE;
              init_over_n = 1'b1;
            end else begin
              idx_n   = idx + 8'd1;
              cnt_n   = '0;
              state_n = ST_GAP;
            end
          end else if (retry < MAX_RETRY) begin
            retry_n = retry + 3'd1;
            cnt_n   = '0;
            state_n = ST_GAP;
          end else begin
            err_idx_n = idx;
            cfg_err_n = 1'b1;
            state_n   = ST_FAIL;
          end
        end
      end
      // A zero GAP_CYC still spends one cycle here.
      ST_GAP: begin
        if (cnt + 16'd1 >= {8'd0, GAP_CYC}) begin
          cnt_n   = '0;
          state_n = ST_FETCH;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      ST_DONE, ST_FAIL: begin
        if (reinit) begin
          init_over_n = 1'b0;
          cfg_err_n   = 1'b0;
          err_idx_n   = '0;
          idx_n       = '0;
          retry_n     = '0;
          state_n     = ST_FETCH;
        end
      end
      default: state_n = ST_WAIT;
    endcase
    busy_n = (state_n != ST_DONE) && (state_n != ST_FAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_WAIT;
      idx       <= '0;
      cnt       <= '0;
      retry     <= '0;
      fetch_ph  <= 1'b0;
      iic_req   <= 1'b0;
      iic_addr  <= '0;
      iic_wdata <= '0;
      init_over <= 1'b0;
      cfg_err   <= 1'b0;
      err_idx   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      retry     <= retry_n;
      fetch_ph  <= fetch_ph_n;
      iic_req   <= req_n;
      iic_addr  <= addr_n;
      iic_wdata <= wdata_n;
      init_over <= init_over_n;
      cfg_err   <= cfg_err_n;
      err_idx   <= err_idx_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_hdmi_cfg_seq.sv
// Bench for hdmi_cfg_seq: directed scenarios plus randomized NACK/ack-delay
// runs checked against a table-walking model of the write sequence.
module tb_hdmi_cfg_seq;
  import hdmi_cfg_pkg::*;

  localparam int NUM  = 4;
  localparam int MAXR = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reinit = 1'b0;
  logic        iic_ack = 1'b0;
  logic        iic_done = 1'b0;
  logic        iic_nack = 1'b0;
  logic        iic_req;
  logic [7:0]  iic_dev;
  logic [15:0] iic_addr;
  logic [7:0]  iic_wdata;
  logic        init_over;
  logic        cfg_err;
  logic [7:0]  err_idx;
  logic        busy;
  cfg_state_t  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [23:0] rom_exp [0:3] = '{24'h128104, 24'h001604, 24'h000901, 24'h000709};
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  bit          nack_q[$];
  int          first_cyc, hold_bad, drop_bad, gap_bad;
  logic [1:0]  pre_flags, post_flags;

  hdmi_cfg_seq #(
    .CFG_NUM     (8'd4),
    .DEV_ADDR    (8'hB2),
    .STARTUP_CYC (16'd16),
    .GAP_CYC     (8'd2),
    .MAX_RETRY   (3'd2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .reinit    (reinit),
    .iic_req   (iic_req),
    .iic_dev   (iic_dev),
    .iic_addr  (iic_addr),
    .iic_wdata (iic_wdata),
    .iic_ack   (iic_ack),
    .iic_done  (iic_done),
    .iic_nack  (iic_nack),
    .init_over (init_over),
    .cfg_err   (cfg_err),
    .err_idx   (err_idx),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #50 clk = ~clk;

  initial begin
    #(100 * 20000);
    errors++;
    $display("FAIL watchdog got timeout want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_req(input int limit, output int cyc, output bit found);
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
      if (iic_req === 1'b1) found = 1'b1;
    end
  endtask

  task automatic pulse_reinit();
    reinit = 1'b1;
    @(posedge clk); #1;
    reinit = 1'b0;
  endtask

  // Serves requests like the IIC master until the sequencer goes quiet or
  // stop_at requests have been accepted (then returns mid-transfer).
  task automatic drive_run(input bit rand_mode, input int nack_entry, input int nack_times,
                           input int first_dly, input int start_limit, input int stop_at);
    int cyc, dly, nk_used;
    bit found, nk;
    logic [23:0] cur;
    obs_q.delete(); nack_q.delete();
    hold_bad = 0; drop_bad = 0; gap_bad = 0; nk_used = 0;
    pre_flags = 2'b11; post_flags = 2'b11;
    wait_req(start_limit, first_cyc, found);
    while (found && obs_q.size() < 20) begin
      cur = {iic_addr, iic_wdata};
      obs_q.push_back(cur);
      if (obs_q.size() == 1) dly = first_dly;
      else dly = rand_mode ? int'($urandom_range(0, 4)) : 1;
      for (int k = 0; k < dly; k++) begin
        @(posedge clk); #1;
        if (iic_req !== 1'b1 || {iic_addr, iic_wdata} !== cur) hold_bad++;
      end
      iic_ack = 1'b1;
      @(posedge clk); #1;
      iic_ack = 1'b0;
      if (iic_req !== 1'b0) drop_bad++;
      if (obs_q.size() == stop_at) return;
      nk = 1'b0;
      if (rand_mode) nk = ($urandom_range(0, 2) == 0);
      else if (nack_entry >= 0) nk = (cur == rom_exp[nack_entry]) && (nk_used < nack_times);
      if (nk) nk_used++;
      nack_q.push_back(nk);
      repeat (4) @(posedge clk);
      #1;
      iic_done = 1'b1; iic_nack = nk;
      pre_flags = {init_over, cfg_err};
      @(posedge clk); #1;
      iic_done = 1'b0; iic_nack = 1'b0;
      post_flags = {init_over, cfg_err};
      wait_req(40, cyc, found);
      if (found && cyc != 4) gap_bad++;
    end
  endtask

  // Reference: walk the table from the recorded NACK decisions.
  task automatic model_run(output bit m_done, output bit m_fail, output logic [7:0] m_idx);
    int idx, tries;
    idx = 0; tries = 0;
    exp_q.delete();
    m_done = 1'b0; m_fail = 1'b0; m_idx = '0;
    foreach (nack_q[i]) begin
      if (m_done || m_fail) break;
      exp_q.push_back(rom_exp[idx]);
      if (nack_q[i]) begin
        tries++;
        if (tries > MAXR) begin m_fail = 1'b1; m_idx = 8'(idx); end
      end else begin
        tries = 0;
        idx++;
        if (idx == NUM) m_done = 1'b1;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (iic_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", iic_req); end
    checks++; if ({iic_addr, iic_wdata} !== 24'h0) begin errors++; $display("FAIL rst_addr_data got %h want 0", {iic_addr, iic_wdata}); end
    checks++; if ({init_over, cfg_err, busy} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {init_over, cfg_err, busy}); end
    checks++; if (err_idx !== 8'h0) begin errors++; $display("FAIL rst_err_idx got %h want 0", err_idx); end
    checks++; if (iic_dev !== 8'hB2) begin errors++; $display("FAIL rst_dev got %h want b2", iic_dev); end
  endtask

  task automatic test_all_ack();
    rst = 1'b0;
    drive_run(1'b0, -1, 0, 1, 60, 99);
    exp_q.delete();
    for (int i = 0; i < NUM; i++) exp_q.push_back(rom_exp[i]);
    checks++; if (first_cyc !== 18) begin errors++; $display("FAIL all_first_req got %0d want 18", first_cyc); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL all_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL all_entry%0d want %h", i, exp_q[i]); end
    end
    checks++; if ({hold_bad, drop_bad, gap_bad} !== 96'd0) begin errors++; $display("FAIL all_timing got hold %0d drop %0d gap %0d want 0 0 0", hold_bad, drop_bad, gap_bad); end
    checks++; if ({pre_flags, post_flags} !== 4'b0010) begin errors++; $display("FAIL all_flag_edge got %b want 0010", {pre_flags, post_flags}); end
    checks++; if ({init_over, cfg_err, busy} !== 3'b100) begin errors++; $display("FAIL all_final got %b want 100", {init_over, cfg_err, busy}); end
  endtask

  task automatic test_nack_then_ack();
    int e[$];
    e = '{0, 1, 2, 2, 3};
    pulse_reinit();
    drive_run(1'b0, 2, 1, 1, 10, 99);
    exp_q.delete();
    foreach (e[i]) exp_q.push_back(rom_exp[e[i]]);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL nack1_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL nack1_entry%0d want %h", i, exp_q[i]); end
    end
    checks++; if ({init_over, cfg_err, busy} !== 3'b100) begin errors++; $display("FAIL nack1_final got %b want 100", {init_over, cfg_err, busy}); end
    checks++; if (gap_bad !== 0) begin errors++; $display("FAIL nack1_gap got %0d want 0", gap_bad); end
  endtask

  task automatic test_nack_exhaust();
    int e[$];
    e = '{0, 1, 1, 1};
    pulse_reinit();
    checks++; if (init_over !== 1'b0) begin errors++; $display("FAIL exh_reinit_clear got %b want 0", init_over); end
    drive_run(1'b0, 1, 99, 1, 10, 99);
    exp_q.delete();
    foreach (e[i]) exp_q.push_back(rom_exp[e[i]]);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL exh_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL exh_entry%0d want %h", i, exp_q[i]); end
    end
    checks++; if ({pre_flags, post_flags} !== 4'b0001) begin errors++; $display("FAIL exh_flag_edge got %b want 0001", {pre_flags, post_flags}); end
    checks++; if ({init_over, cfg_err, busy} !== 3'b010) begin errors++; $display("FAIL exh_final got %b want 010", {init_over, cfg_err, busy}); end
    checks++; if (err_idx !== 8'd1) begin errors++; $display("FAIL exh_err_idx got %0d want 1", err_idx); end
  endtask

  task automatic test_delayed_ack();
    pulse_reinit();
    checks++; if ({cfg_err, err_idx} !== 9'd0) begin errors++; $display("FAIL dly_reinit_clear got %h want 0", {cfg_err, err_idx}); end
    drive_run(1'b0, -1, 0, 7, 10, 99);
    checks++; if (hold_bad !== 0) begin errors++; $display("FAIL dly_hold got %0d want 0", hold_bad); end
    checks++; if (drop_bad !== 0) begin errors++; $display("FAIL dly_drop got %0d want 0", drop_bad); end
    checks++; if (obs_q.size() != NUM) begin errors++; $display("FAIL dly_count got %0d want %0d", obs_q.size(), NUM); end
    checks++; if (init_over !== 1'b1) begin errors++; $display("FAIL dly_final got %b want 1", init_over); end
  endtask

  task automatic test_reinit();
    int cyc;
    bit found;
    pulse_reinit();
    checks++; if ({init_over, busy} !== 2'b01) begin errors++; $display("FAIL reinit_fall got %b want 01", {init_over, busy}); end
    wait_req(10, cyc, found);
    checks++; if (cyc !== 2 || !found) begin errors++; $display("FAIL reinit_first_req got %0d want 2", cyc); end
    checks++; if ({iic_addr, iic_wdata} !== rom_exp[0]) begin errors++; $display("FAIL reinit_entry0 got %h want %h", {iic_addr, iic_wdata}, rom_exp[0]); end
    iic_ack = 1'b1;
    @(posedge clk); #1;
    iic_ack = 1'b0;
    pulse_reinit();
    checks++; if ({iic_req, busy} !== 2'b01) begin errors++; $display("FAIL reinit_xfer_ignored got %b want 01", {iic_req, busy}); end
    repeat (3) @(posedge clk);
    #1;
    iic_done = 1'b1;
    @(posedge clk); #1;
    iic_done = 1'b0;
    drive_run(1'b0, -1, 0, 1, 10, 99);
    checks++; if (first_cyc !== 4) begin errors++; $display("FAIL reinit_gap got %0d want 4", first_cyc); end
    checks++; if (obs_q.size() != 3 || obs_q[0] !== rom_exp[1]) begin errors++; $display("FAIL reinit_continue got %0d reqs want 3 from entry 1", obs_q.size()); end
    checks++; if (init_over !== 1'b1) begin errors++; $display("FAIL reinit_final got %b want 1", init_over); end
  endtask

  task automatic test_reset_mid();
    pulse_reinit();
    drive_run(1'b0, -1, 0, 1, 10, 3);
    checks++; if (obs_q.size() != 3 || obs_q[2] !== rom_exp[2]) begin errors++; $display("FAIL rmid_reach got %0d reqs want 3", obs_q.size()); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({iic_req, iic_addr, iic_wdata, init_over, cfg_err, err_idx, busy} !== 36'd0) begin
      errors++; $display("FAIL rmid_outputs got %h want 0", {iic_req, iic_addr, iic_wdata, init_over, cfg_err, err_idx, busy});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_run(1'b0, -1, 0, 1, 60, 99);
    checks++; if (first_cyc !== 18) begin errors++; $display("FAIL rmid_first_req got %0d want 18", first_cyc); end
    checks++; if (obs_q.size() != NUM || obs_q[0] !== rom_exp[0]) begin errors++; $display("FAIL rmid_restart got %0d reqs want %0d from entry 0", obs_q.size(), NUM); end
    checks++; if (init_over !== 1'b1) begin errors++; $display("FAIL rmid_final got %b want 1", init_over); end
  endtask

  task automatic test_random();
    bit m_done, m_fail;
    logic [7:0] m_idx;
    for (int r = 0; r < 8; r++) begin
      pulse_reinit();
      drive_run(1'b1, -1, 0, int'($urandom_range(0, 4)), 10, 99);
      model_run(m_done, m_fail, m_idx);
      checks++; if (first_cyc !== 2) begin errors++; $display("FAIL rnd%0d_first_req got %0d want 2", r, first_cyc); end
      checks++; if (!(m_done || m_fail)) begin errors++; $display("FAIL rnd%0d_ended got %0d reqs want terminated sequence", r, obs_q.size()); end
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", r, obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        checks++;
        if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_entry%0d want %h", r, i, exp_q[i]); end
      end
      checks++; if ({hold_bad, drop_bad, gap_bad} !== 96'd0) begin errors++; $display("FAIL rnd%0d_timing got hold %0d drop %0d gap %0d want 0 0 0", r, hold_bad, drop_bad, gap_bad); end
      checks++; if ({init_over, cfg_err, busy} !== {m_done, m_fail, 1'b0}) begin errors++; $display("FAIL rnd%0d_flags got %b want %b", r, {init_over, cfg_err, busy}, {m_done, m_fail, 1'b0}); end
      if (m_fail) begin
        checks++; if (err_idx !== m_idx) begin errors++; $display("FAIL rnd%0d_err_idx got %0d want %0d", r, err_idx, m_idx); end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_all_ack();
    test_nack_then_ack();
    test_nack_exhaust();
    test_delayed_ack();
    test_reinit();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
